// File: rtl/alu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings and controller states.
package alu_muldiv_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH:0]   part_hi_i,
  input  logic [WIDTH-1:0] part_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH:0]   part_hi_o,
  output logic [WIDTH-1:0] part_lo_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sum     = part_hi_i + (part_lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {part_hi_i[WIDTH-1:0], part_lo_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    ge      = (shifted >= {1'b0, opnd_i});
    if (is_div_i) begin
      // Quotient bit enters through the LSB freed by the left shift; the caller merges it.
      part_hi_o = ge ? diff : shifted;
      part_lo_o = {part_lo_i[WIDTH-2:0], 1'b0};
      q_bit_o   = ge;
    end else begin
      part_hi_o = {1'b0, sum[WIDTH:1]};
      part_lo_o = {sum[0], part_lo_i[WIDTH-1:1]};
      q_bit_o   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative signed/unsigned multiply/divide with HI/LO registers.
// state | meaning: IDLE accept ops / MTHI / MTLO; RUN one step per cycle; FIX sign-correct and write HI/LO.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [OP_WIDTH-1:0] op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_t              op_in;
  logic             is_div_q;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             step_q;

  logic             signed_op, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign op_in    = op_t'(op_i);
  assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (is_div_q),
    .part_hi_i (acc_hi_q),
    .part_lo_i (acc_lo_q),
    .opnd_i    (opnd_q),
    .part_hi_o (step_hi),
    .part_lo_o (step_lo),
    .q_bit_o   (step_q)
  );

  assign prod_mag = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_res = neg_res_q ? -prod_mag : prod_mag;
  assign quo_res  = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_res  = neg_rem_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    sa        = signed_op & a_i[WIDTH-1];
    sb        = signed_op & b_i[WIDTH-1];
    // W-bit unsigned magnitudes: the most negative value maps to 2^(W-1), which still fits.
    mag_a     = sa ? -a_i : a_i;
    mag_b     = sb ? -b_i : b_i;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (op_in)
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d      = op_in;
              a_raw_d   = a_i;
              dz_d      = (b_i == '0);
              neg_res_d = sa ^ sb;
              neg_rem_d = sa;
              acc_hi_d  = '0;
              if ((op_in == OP_DIV) || (op_in == OP_DIVU)) begin
                acc_lo_d = mag_a;
                opnd_d   = mag_b;
              end else begin
                acc_lo_d = mag_b;
                opnd_d   = mag_a;
              end
              cnt_d   = CNT_W'(WIDTH - 1);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = {step_lo[WIDTH-1:1], step_lo[0] | step_q};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        if (is_div_q) begin
          if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end else begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32: results, latency, busy/done timing, reset abort.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    cyc();
    start = 1'b0; op = 3'b110;
  endtask

  // Samples 41 cycles after an issue; k=0 is the sample right after the start edge.
  task automatic observe(output int lat, output int bc, output int dc);
    lat = -1; bc = 0; dc = 0;
    for (int k = 0; k <= 40; k++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (lat < 0) lat = k;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    cyc(); cyc();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (hi !== '0) begin fails++; $display("FAIL reset_hi got %h exp 0", hi); end
    tests++; if (lo !== '0) begin fails++; $display("FAIL reset_lo got %h exp 0", lo); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_multu();
    int lat, bc, dc;
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    observe(lat, bc, dc);
    tests++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
    tests++; if (lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo got %h exp 00000001", lo); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL multu_latency got %0d exp 33", lat); end
    tests++; if (bc !== 33) begin fails++; $display("FAIL multu_busy_cycles got %0d exp 33", bc); end
    tests++; if (dc !== 1) begin fails++; $display("FAIL multu_done_pulses got %0d exp 1", dc); end
  endtask

  task automatic test_signed();
    int lat, bc, dc;
    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    observe(lat, bc, dc);
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_neg_hi got %h exp ffffffff", hi); end
    tests++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_neg_lo got %h exp ffffffeb", lo); end
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    observe(lat, bc, dc);
    tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_quo got %h exp fffffffd", lo); end
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_rem got %h exp ffffffff", hi); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL div_latency got %0d exp 33", lat); end
    issue(3'b000, 32'h80000000, 32'h80000000);
    observe(lat, bc, dc);
    tests++; if (hi !== 32'h40000000) begin fails++; $display("FAIL mult_minmin_hi got %h exp 40000000", hi); end
    tests++; if (lo !== 32'h00000000) begin fails++; $display("FAIL mult_minmin_lo got %h exp 00000000", lo); end
    issue(3'b010, 32'd47, 32'hFFFFFFFB);
    observe(lat, bc, dc);
    tests++; if (lo !== 32'hFFFFFFF7) begin fails++; $display("FAIL div_posneg_quo got %h exp fffffff7", lo); end
    tests++; if (hi !== 32'd2) begin fails++; $display("FAIL div_posneg_rem got %h exp 00000002", hi); end
  endtask

  task automatic test_div_special();
    int lat, bc, dc;
    issue(3'b011, 32'd100, 32'd0);
    observe(lat, bc, dc);
    tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu_zero_lo got %h exp ffffffff", lo); end
    tests++; if (hi !== 32'd100) begin fails++; $display("FAIL divu_zero_hi got %h exp 00000064", hi); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL divu_zero_latency got %0d exp 33", lat); end
    issue(3'b010, 32'hFFFFFFFB, 32'd0);
    observe(lat, bc, dc);
    tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_zero_lo got %h exp ffffffff", lo); end
    tests++; if (hi !== 32'hFFFFFFFB) begin fails++; $display("FAIL div_zero_hi got %h exp fffffffb", hi); end
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    observe(lat, bc, dc);
    tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
    tests++; if (hi !== 32'h00000000) begin fails++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
  endtask

  task automatic test_move();
    logic [W-1:0] lo_before;
    lo_before = lo;
    issue(3'b100, 32'h12345678, 32'h0);
    tests++; if (hi !== 32'h12345678) begin fails++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mthi_done got %b exp 0", done); end
    tests++; if (lo !== lo_before) begin fails++; $display("FAIL mthi_lo_kept got %h exp %h", lo, lo_before); end
    issue(3'b101, 32'hCAFEF00D, 32'h0);
    tests++; if (lo !== 32'hCAFEF00D) begin fails++; $display("FAIL mtlo_lo got %h exp cafef00d", lo); end
    tests++; if (hi !== 32'h12345678) begin fails++; $display("FAIL mtlo_hi_kept got %h exp 12345678", hi); end
    issue(3'b110, 32'h11111111, 32'h22222222);
    cyc();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nop_busy got %b exp 0", busy); end
    tests++; if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
      fails++; $display("FAIL nop_hilo got %h/%h exp 12345678/cafef00d", hi, lo);
    end
  endtask

  task automatic test_ignore_start();
    int lat, dc;
    issue(3'b001, 32'd6, 32'd7);
    lat = -1; dc = 0;
    for (int k = 0; k <= 40; k++) begin
      if (done) begin
        dc++;
        if (lat < 0) lat = k;
      end
      // k=32 drives start onto the FIX edge.
      start = (k == 5) || (k == 32);
      op = 3'b000; a = 32'd1; b = 32'd1;
      cyc();
    end
    start = 1'b0; op = 3'b110;
    tests++; if (lo !== 32'd42) begin fails++; $display("FAIL ignore_lo got %h exp 0000002a", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL ignore_hi got %h exp 00000000", hi); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL ignore_latency got %0d exp 33", lat); end
    tests++; if (dc !== 1) begin fails++; $display("FAIL ignore_done_pulses got %0d exp 1", dc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int k;
    int lat, bc, dc;
    issue(3'b011, 32'd1000, 32'd7);
    k = 0;
    while (!done && k < 40) begin
      cyc();
      k++;
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got %b exp 1 (timeout)", done); end
    tests++; if (lo !== 32'd142 || hi !== 32'd6) begin
      fails++; $display("FAIL b2b_first_result got %h/%h exp 0000008e/00000006", lo, hi);
    end
    issue(3'b011, 32'd17, 32'd5);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got busy %b exp 1", busy); end
    observe(lat, bc, dc);
    tests++; if (lo !== 32'd3 || hi !== 32'd2) begin
      fails++; $display("FAIL b2b_second_result got %h/%h exp 00000003/00000002", lo, hi);
    end
    tests++; if (lat !== 33) begin fails++; $display("FAIL b2b_latency got %0d exp 33", lat); end
  endtask

  task automatic test_reset_mid();
    int bc, dc;
    issue(3'b000, 32'd123, 32'd456);
    for (int k = 0; k < 10; k++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    tests++; if (hi !== '0 || lo !== '0) begin fails++; $display("FAIL rst_mid_hilo got %h/%h exp 0/0", hi, lo); end
    bc = 0; dc = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) bc++;
      if (done) dc++;
      cyc();
    end
    tests++; if (dc !== 0) begin fails++; $display("FAIL rst_mid_done_pulses got %0d exp 0", dc); end
    tests++; if (bc !== 0) begin fails++; $display("FAIL rst_mid_busy_cycles got %0d exp 0", bc); end
    tests++; if (hi !== '0 || lo !== '0) begin fails++; $display("FAIL rst_mid_hilo_after got %h/%h exp 0/0", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_special();
    test_move();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
